// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Decode-stage immediate generator for RV32/RV64. Extracts the
//               U/B/J/I/S/ZIMM/SHAMT immediate from a raw instruction word,
//               extends it to XLEN and presents it behind a valid/ready
//               handshake with a 2-entry skid buffer (output register plus
//               one skid register), so in_ready never depends on out_ready
//               combinationally.
// Ports       : clk, rst_n (async, active low), flush (sync drop of all
//               entries); in_valid/in_ready/in_instr/in_fmt upstream;
//               out_valid/out_ready/out_imm/out_err downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_fmt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_err
);

    localparam logic [2:0] c_fmt_none  = 3'd0;
    localparam logic [2:0] c_fmt_u     = 3'd1;
    localparam logic [2:0] c_fmt_b     = 3'd2;
    localparam logic [2:0] c_fmt_j     = 3'd3;
    localparam logic [2:0] c_fmt_i     = 3'd4;
    localparam logic [2:0] c_fmt_s     = 3'd5;
    localparam logic [2:0] c_fmt_zimm  = 3'd6;
    localparam logic [2:0] c_fmt_shamt = 3'd7;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_out_imm;
    logic            r_out_err;
    logic [XLEN-1:0] r_skid_imm;
    logic            r_skid_err;
    logic [XLEN-1:0] w_imm;
    logic            w_err;
    logic            w_accept;
    logic            w_drain;
    logic            w_load_out_new;
    logic            w_load_out_skid;
    logic            w_load_skid;

    // The opcode field never contributes to any immediate.
    logic w_unused_opcode;
    assign w_unused_opcode = ^in_instr[6:0];

    // ------------------------------------------------------------------
    // Immediate extraction. Casting a signed operand to XLEN sign-extends;
    // casting an unsigned operand zero-extends.
    // ------------------------------------------------------------------
    always_comb begin
        w_imm = '0;
        w_err = 1'b0;
        case (in_fmt)
            c_fmt_u:
                w_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            c_fmt_b:
                w_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                       in_instr[11:8], 1'b0}));
            c_fmt_j:
                w_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                       in_instr[30:21], 1'b0}));
            c_fmt_i:
                w_imm = XLEN'($signed(in_instr[31:20]));
            c_fmt_s:
                w_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            c_fmt_zimm:
                w_imm = XLEN'(in_instr[19:15]);
            c_fmt_shamt: begin
                w_imm = XLEN'(in_instr[20 +: SHAMT_W]);
                // On RV32 a shift amount of 32 or more is illegal.
                w_err = (XLEN == 32) && in_instr[25];
            end
            c_fmt_none: begin
                w_imm = '0;
                w_err = 1'b1;
            end
            default: begin
                w_imm = '0;
                w_err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Occupancy FSM. Handshake outputs decode straight from the state
    // register, so in_ready has no path from out_ready.
    // ------------------------------------------------------------------
    assign in_ready  = (r_state != S_TWO);
    assign out_valid = (r_state != S_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_new  = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        if (flush) begin
            // Flush wins over any same-cycle accept or drain.
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_load_out_new = 1'b1;
                        w_state_nxt    = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_out_new = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = S_TWO;
                    end else if (w_drain) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_drain) begin
                        w_load_out_skid = 1'b1;
                        w_state_nxt     = S_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Data registers: only written on an explicit load, so a stalled
    // output stays stable and nothing undefined leaks out.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_imm  <= '0;
            r_out_err  <= 1'b0;
            r_skid_imm <= '0;
            r_skid_err <= 1'b0;
        end else begin
            if (w_load_out_new) begin
                r_out_imm <= w_imm;
                r_out_err <= w_err;
            end else if (w_load_out_skid) begin
                r_out_imm <= r_skid_imm;
                r_out_err <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_imm;
                r_skid_err <= w_err;
            end
        end
    end

    assign out_imm = r_out_imm;
    assign out_err = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench for imm_gen_pipe. Drives an XLEN=64 and
//               an XLEN=32 instance with identical inputs and compares both
//               against a queue-based reference model whose immediates are
//               computed arithmetically from the instruction fields.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [2:0]  in_fmt = '0;
    logic        out_ready = 1'b0;

    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_fmt(in_fmt),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_err(out_err64)
    );

    imm_gen_pipe #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_fmt(in_fmt),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_err(out_err32)
    );

    typedef struct {
        logic [63:0] imm64;
        logic [63:0] imm32;
        logic        err64;
        logic        err32;
    } exp_t;

    exp_t        q[$];
    logic [63:0] seen[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        last_drain = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
        if (((v >> (bits - 1)) & 64'd1) != 0) return v - (64'd1 << bits);
        return v;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [2:0] fmt, input logic [31:0] ins,
                                            input int xlen, output logic err);
        logic [63:0] w;
        logic [63:0] r;
        w   = {32'b0, ins};
        err = 1'b0;
        case (fmt)
            3'd1: r = sext(w & 64'hFFFF_F000, 32);
            3'd2: r = sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                           (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
            3'd3: r = sext((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                           (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
            3'd4: r = sext((w >> 20) & 4095, 12);
            3'd5: r = sext((((w >> 25) & 127) << 5) | ((w >> 7) & 31), 12);
            3'd6: r = (w >> 15) & 31;
            3'd7: begin
                if (xlen == 64) begin
                    r = (w >> 20) & 63;
                end else begin
                    r   = (w >> 20) & 31;
                    err = ins[25];
                end
            end
            default: begin
                r   = 64'd0;
                err = 1'b1;
            end
        endcase
        if (xlen == 32) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    // One clock of handshake: check outputs at the falling edge against the
    // model, then advance the model at the rising edge. Called at posedge+1.
    task automatic cycle();
        logic acc, drn;
        exp_t e;
        @(negedge clk);
        check("in_ready64", {63'b0, in_ready64}, {63'b0, q.size() < 2});
        check("in_ready32", {63'b0, in_ready32}, {63'b0, q.size() < 2});
        check("out_valid64", {63'b0, out_valid64}, {63'b0, q.size() > 0});
        check("out_valid32", {63'b0, out_valid32}, {63'b0, q.size() > 0});
        if (q.size() > 0) begin
            check("out_imm64", out_imm64, q[0].imm64);
            check("out_err64", {63'b0, out_err64}, {63'b0, q[0].err64});
            check("out_imm32", {32'b0, out_imm32}, q[0].imm32);
            check("out_err32", {63'b0, out_err32}, {63'b0, q[0].err32});
        end
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        if (acc) begin
            e.imm64 = ref_imm(in_fmt, in_instr, 64, e.err64);
            e.imm32 = ref_imm(in_fmt, in_instr, 32, e.err32);
        end
        if (drn && !flush) seen.push_back(out_imm64);
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        last_drain = drn && !flush;
        #1;
    endtask

    // Directed vectors: fmt, instr, expected imm/err for XLEN=64 and XLEN=32.
    logic [2:0]  v_fmt[10]  = '{3'd1, 3'd1, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6, 3'd7, 3'd0, 3'd7};
    logic [31:0] v_ins[10]  = '{32'h123450B7, 32'h800000B7, 32'hFFF00093, 32'hFE20BC23,
                                32'hFE000EE3, 32'hFF9FF06F, 32'h800F8000, 32'h03F00000,
                                32'hFFFFFFFF, 32'h01500000};
    logic [63:0] v_e64[10]  = '{64'h0000000012345000, 64'hFFFFFFFF80000000,
                                64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF8,
                                64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                64'h000000000000001F, 64'h000000000000003F,
                                64'h0, 64'h0000000000000015};
    logic        v_r64[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic [31:0] v_e32[10]  = '{32'h12345000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF8,
                                32'hFFFFFFFC, 32'hFFFFFFF8, 32'h0000001F, 32'h0000001F,
                                32'h0, 32'h00000015};
    logic        v_r32[10]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k;
        int drains;
        int max_occ;
        logic pred;

        // Reset values while rst_n is held low.
        #3;
        check("rst_out_valid64", {63'b0, out_valid64}, 64'd0);
        check("rst_in_ready64", {63'b0, in_ready64}, 64'd1);
        check("rst_out_imm64", out_imm64, 64'd0);
        check("rst_out_err64", {63'b0, out_err64}, 64'd0);
        check("rst_out_imm32", {32'b0, out_imm32}, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed format vectors, one at a time.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_fmt   = v_fmt[i];
            in_instr = v_ins[i];
            cycle();
            in_valid = 1'b0;
            check($sformatf("vec%0d_imm64", i), out_imm64, v_e64[i]);
            check($sformatf("vec%0d_err64", i), {63'b0, out_err64}, {63'b0, v_r64[i]});
            check($sformatf("vec%0d_imm32", i), {32'b0, out_imm32}, {32'b0, v_e32[i]});
            check($sformatf("vec%0d_err32", i), {63'b0, out_err32}, {63'b0, v_r32[i]});
            cycle();
        end

        // Backpressure: three I-type immediates 1, 2, 3 with out_ready low.
        seen.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 3'd4;
        k = 1;
        for (int t = 0; t < 6; t++) begin
            in_instr = (32'(k) << 20) | 32'h13;
            pred = (q.size() < 2);
            cycle();
            if (pred && k < 3) k++;
        end
        check("bp_in_ready", {63'b0, in_ready64}, 64'd0);
        check("bp_head", out_imm64, 64'd1);
        out_ready = 1'b1;
        for (int t = 0; t < 10 && in_valid; t++) begin
            pred = (q.size() < 2);
            cycle();
            if (pred) in_valid = 1'b0;
        end
        for (int t = 0; t < 10 && q.size() > 0; t++) cycle();
        check("bp_count", 64'(seen.size()), 64'd3);
        for (int i = 0; i < 3 && i < seen.size(); i++)
            check($sformatf("bp_order%0d", i), seen[i], 64'(i + 1));

        // Full-throughput streaming.
        drains  = 0;
        max_occ = 0;
        in_valid = 1'b1;
        for (int t = 0; t < 16; t++) begin
            in_fmt   = 3'($urandom_range(1, 7));
            in_instr = $urandom;
            cycle();
            if (last_drain) drains++;
            if (q.size() > max_occ) max_occ = q.size();
        end
        in_valid = 1'b0;
        cycle();
        if (last_drain) drains++;
        check("stream_drains", 64'(drains), 64'd16);
        check("stream_max_occ", 64'(max_occ), 64'd1);

        // Randomised traffic with occasional flushes.
        for (int t = 0; t < 300; t++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_fmt    = 3'($urandom_range(0, 7));
            in_instr  = $urandom;
            cycle();
        end
        flush = 1'b0;

        // Flush while full with a same-cycle input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 3'd4;
        for (int t = 0; t < 4; t++) begin
            in_instr = $urandom;
            cycle();
        end
        check("pre_flush_full", {63'b0, in_ready64}, 64'd0);
        flush = 1'b1;
        cycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("flush_out_valid", {63'b0, out_valid64}, 64'd0);
        check("flush_in_ready", {63'b0, in_ready64}, 64'd1);
        drains = 0;
        for (int t = 0; t < 3; t++) begin
            cycle();
            if (last_drain) drains++;
        end
        check("flush_no_output", 64'(drains), 64'd0);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 3'd1;
        in_instr  = 32'hABCDE037;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid64", {63'b0, out_valid64}, 64'd0);
        check("arst_out_valid32", {63'b0, out_valid32}, 64'd0);
        check("arst_out_imm64", out_imm64, 64'd0);
        check("arst_in_ready64", {63'b0, in_ready64}, 64'd1);
        q.delete();
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cycle();
        check("post_rst_in_ready", {63'b0, in_ready64}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage of the RV32/RV64 core.
- Covers every immediate format: U, B, J, I, S, CSR zimm and shift-amount.
- Sign- or zero-extends each immediate to XLEN.
- Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so decode can stall or flush without a combinational ready path from execute.

Parameters:
XLEN, 64, datapath width of out_imm; legal values 32 or 64.
SHAMT_W, (XLEN==64 ? 6 : 5), width of the shift-amount field taken from instr[25:20].

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous pipeline flush; drops all buffered entries.
in_valid  input  1  upstream has an instruction.
in_ready  output  1  block can accept; registered, depends only on occupancy.
in_instr  input  32  raw instruction word.
in_fmt  input  3  0 NONE, 1 U, 2 B, 3 J, 4 I, 5 S, 6 ZIMM, 7 SHAMT.
out_valid  output  1  out_imm/out_err are valid.
out_ready  input  1  downstream accepts.
out_imm  output  XLEN  extended immediate.
out_err  output  1  illegal immediate for this XLEN.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, in_ready=1, out_imm=0, out_err=0, occupancy=0. Both entries are cleared.
- Extension rules (sign bit is instr[31] unless stated):
  - U: {sext instr[31:12], 12'b0}.
  - B: sext {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - J: sext {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - I: sext instr[31:20].
  - S: sext {instr[31:25], instr[11:7]}.
  - ZIMM: zero-extend instr[19:15].
  - SHAMT: zero-extend instr[20+SHAMT_W-1:20].
  - NONE: imm=0, err=1.
- SHAMT with XLEN=32 and instr[25]=1: err=1, imm still = zext instr[24:20].
- All other formats: err=0.
- Latency: an accepted instruction appears on out_* the next cycle at the earliest.
- Occupancy state machine, EMPTY/ONE/TWO:
  - EMPTY: in_ready=1, out_valid=0. Accept -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept and no drain -> TWO.
    - Drain and no accept -> EMPTY.
    - Accept and drain together -> ONE, with the new entry on out_* next cycle.
  - TWO: in_ready=0, out_valid=1. Drain -> ONE, and the skid entry moves to the output register.
  - Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Order is strictly FIFO. While out_valid & !out_ready, out_imm/out_err must be held stable.
- in_valid while in_ready=0 is ignored; upstream must hold its data.
- flush: next cycle occupancy=0, out_valid=0, in_ready=1.
  - flush overrides any same-cycle accept or drain; the accepted word is discarded.
- Reset asserted mid-transfer: all state cleared immediately; no partial output.
- No X propagation: the output register updates only on load; imm for NONE is 0.

Test Plan:
- XLEN=64, fmt U, instr 0x123450B7 -> out_imm 0x0000000012345000 one cycle later. instr 0x800000B7 -> 0xFFFFFFFF80000000.
- fmt I, 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF. fmt S, 0xFE20BC23 -> 0xFFFFFFFFFFFFFFF8. fmt B, 0xFE000EE3 -> 0xFFFFFFFFFFFFFFFC. fmt J, 0xFF9FF06F -> 0xFFFFFFFFFFFFFFF8. All with err=0.
- fmt ZIMM, instr bits[19:15]=0x1F with instr[31]=1 -> 0x000000000000001F. fmt SHAMT, instr[25:20]=0x3F: XLEN=64 -> 0x3F, err=0; XLEN=32 -> 0x1F, err=1. fmt NONE -> imm 0, err=1.
- Backpressure: out_ready=0, push 3 back-to-back I-type immediates 1, 2, 3.
  - in_ready drops after the 2nd; the 3rd is held upstream.
  - Raising out_ready yields 1, 2, 3 in order with no loss or duplication. out_imm stays stable while stalled.
- Full-throughput streaming with out_ready=1: 16 consecutive instructions -> 16 outputs on 16 consecutive cycles, occupancy never reaches TWO.
- Flush in TWO with in_valid=1 the same cycle -> next cycle out_valid=0, in_ready=1, no outputs. Async rst_n pulse mid-stream -> out_valid=0 immediately, in_ready=1 after release.
